bp_fe_lce_resp_arb: RTL and testbench

BP_FE_LCE_RESP_ARB -- requirements
Module: bp_fe_lce_resp_arb

---
 rtl/bp_fe_lce_resp_arb.sv | 189 ++++++++++++++++++
 tb/tb_bp_fe_lce_resp_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_lce_resp_arb.sv
// bp_fe_lce_resp_arb
//
// Merges LCE responses from the request side and the command side into a
// single registered output toward the CCE. Each source has its own 2-entry
// FIFO; an arbiter loads one FIFO head into the output register whenever that
// register is empty or draining. The request side normally wins.
//
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   req_resp_i / _v_i / _ready_o  request-side response input (valid/ready)
//   cmd_resp_i / _v_i / _ready_o  command-side sync/invalidate ack input
//   lce_resp_o / _v_o / _ready_i  arbitrated response to the CCE
//   grant_src_o                 source of lce_resp_o (0 = req, 1 = cmd)
//
// Optional feature: define BP_FE_LCE_RESP_ARB_STARVE_EN to add a starvation
// counter that forces a command-side grant after starve_limit_p consecutive
// request-side grants made while the command FIFO was waiting.
module bp_fe_lce_resp_arb #(
  parameter int unsigned resp_width_p   = 64,
  parameter int unsigned starve_limit_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [resp_width_p-1:0] req_resp_i,
  input  logic                    req_resp_v_i,
  output logic                    req_resp_ready_o,
  input  logic [resp_width_p-1:0] cmd_resp_i,
  input  logic                    cmd_resp_v_i,
  output logic                    cmd_resp_ready_o,
  output logic [resp_width_p-1:0] lce_resp_o,
  output logic                    lce_resp_v_o,
  input  logic                    lce_resp_ready_i,
  output logic                    grant_src_o
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  // Index 0 = request side, index 1 = command side.
  logic [resp_width_p-1:0] in_data [2];
  logic [resp_width_p-1:0] head    [2];
  logic [1:0]              in_v;
  logic [1:0]              in_ready;
  logic [1:0]              enq;
  logic [1:0]              deq;
  logic [1:0]              nonempty;

  assign in_data[0]       = req_resp_i;
  assign in_data[1]       = cmd_resp_i;
  assign in_v             = {cmd_resp_v_i, req_resp_v_i};
  assign req_resp_ready_o = in_ready[0];
  assign cmd_resp_ready_o = in_ready[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [resp_width_p-1:0] mem_q [2];
      logic [resp_width_p-1:0] mem_d [2];
      logic                    wr_ptr_q, wr_ptr_d;
      logic                    rd_ptr_q, rd_ptr_d;
      logic [1:0]              count_q, count_d;

      // Ready looks only at the registered count, so a full FIFO stays
      // not-ready even in a cycle where it is being popped. It is also held
      // low while reset is asserted.
      assign in_ready[gi] = reset_n_i && (count_q != 2'd2);
      assign enq[gi]      = in_v[gi] && in_ready[gi];
      assign nonempty[gi] = (count_q != 2'd0);
      assign head[gi]     = mem_q[rd_ptr_q];

      always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq[gi]) begin
          mem_d[wr_ptr_q] = in_data[gi];
          wr_ptr_d        = ~wr_ptr_q;
        end
        if (deq[gi]) begin
          rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, enq[gi]} - {1'b0, deq[gi]};
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          mem_q[0] <= '0;
          mem_q[1] <= '0;
          wr_ptr_q <= 1'b0;
          rd_ptr_q <= 1'b0;
          count_q  <= 2'd0;
        end else begin
          mem_q    <= mem_d;
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end
    end
  endgenerate

  // Arbitration
  state_e                  state_q, state_d;
  logic                    out_v_q, out_v_d;
  logic                    out_src_q, out_src_d;
  logic [resp_width_p-1:0] out_data_q, out_data_d;
  logic                    load;
  logic                    sel_cmd;
  logic                    starve_force;

  // The output register can take a new entry when empty or draining.
  assign load    = (!out_v_q || lce_resp_ready_i) && (|nonempty);
  assign sel_cmd = nonempty[1] && (!nonempty[0] || starve_force);
  assign deq     = load ? (sel_cmd ? 2'b10 : 2'b01) : 2'b00;

`ifdef BP_FE_LCE_RESP_ARB_STARVE_EN
  localparam int unsigned CNT_W = ($clog2(starve_limit_p + 1) > 0) ?
                                  $clog2(starve_limit_p + 1) : 1;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = (starve_cnt_q >= CNT_W'(starve_limit_p));

  // Counts request-side grants made while the cmd FIFO is waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!nonempty[1] || (load && sel_cmd)) begin
      starve_cnt_d = '0;
    end else if (load && (starve_cnt_q < CNT_W'(starve_limit_p))) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    out_v_d    = out_v_q;
    out_src_d  = out_src_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d    = HOLD;
          out_v_d    = 1'b1;
          out_src_d  = sel_cmd;
          out_data_d = sel_cmd ? head[1] : head[0];
        end
      end
      HOLD: begin
        if (lce_resp_ready_i) begin
          if (load) begin
            out_src_d  = sel_cmd;
            out_data_d = sel_cmd ? head[1] : head[0];
          end else begin
            state_d = IDLE;
            out_v_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      out_v_q    <= 1'b0;
      out_src_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      out_v_q    <= out_v_d;
      out_src_q  <= out_src_d;
      out_data_q <= out_data_d;
    end
  end

  assign lce_resp_o   = out_data_q;
  assign lce_resp_v_o = out_v_q;
  assign grant_src_o  = out_src_q;

endmodule

// File: tb/tb_bp_fe_lce_resp_arb.sv
// Testbench for bp_fe_lce_resp_arb: directed scenarios plus random traffic,
// every cycle compared against a queue-based transaction model.
module tb_bp_fe_lce_resp_arb;

  localparam int W     = 64;
  localparam int LIMIT = 8;
`ifdef BP_FE_LCE_RESP_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n_i = 1'b0;
  logic [W-1:0] req_resp_i = '0;
  logic         req_resp_v_i = 1'b0;
  logic         req_resp_ready_o;
  logic [W-1:0] cmd_resp_i = '0;
  logic         cmd_resp_v_i = 1'b0;
  logic         cmd_resp_ready_o;
  logic [W-1:0] lce_resp_o;
  logic         lce_resp_v_o;
  logic         lce_resp_ready_i = 1'b0;
  logic         grant_src_o;

  always #5 clk = ~clk;

  bp_fe_lce_resp_arb #(.resp_width_p(W), .starve_limit_p(LIMIT)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n_i),
    .req_resp_i       (req_resp_i),
    .req_resp_v_i     (req_resp_v_i),
    .req_resp_ready_o (req_resp_ready_o),
    .cmd_resp_i       (cmd_resp_i),
    .cmd_resp_v_i     (cmd_resp_v_i),
    .cmd_resp_ready_o (cmd_resp_ready_o),
    .lce_resp_o       (lce_resp_o),
    .lce_resp_v_o     (lce_resp_v_o),
    .lce_resp_ready_i (lce_resp_ready_i),
    .grant_src_o      (grant_src_o)
  );

  int chk_count  = 0;
  int fail_count = 0;

  // Reference model: queued messages per source and the output slot.
  logic [W-1:0] q_req[$];
  logic [W-1:0] q_cmd[$];
  bit           m_v    = 1'b0;
  logic [W-1:0] m_data = '0;
  bit           m_src  = 1'b0;
  int           m_wait = 0;   // req grants while cmd has been waiting

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_req.delete();
    q_cmd.delete();
    m_v    = 1'b0;
    m_src  = 1'b0;
    m_wait = 0;
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic cycle(input bit rv, input logic [W-1:0] rd,
                       input bit cv, input logic [W-1:0] cd, input bit ri);
    bit acc_r, acc_c, has_out_room, pick_cmd, ld;
    req_resp_v_i     = rv;
    req_resp_i       = rd;
    cmd_resp_v_i     = cv;
    cmd_resp_i       = cd;
    lce_resp_ready_i = ri;
    acc_r        = rv && (q_req.size() < 2);
    acc_c        = cv && (q_cmd.size() < 2);
    has_out_room = !m_v || ri;
    ld           = has_out_room && (q_req.size() > 0 || q_cmd.size() > 0);
    pick_cmd     = (q_cmd.size() > 0) &&
                   (q_req.size() == 0 || (STARVE && m_wait >= LIMIT));
    if (q_cmd.size() == 0 || (ld && pick_cmd)) m_wait = 0;
    else if (ld && m_wait < LIMIT) m_wait++;
    if (ld) begin
      m_v    = 1'b1;
      m_src  = pick_cmd;
      m_data = pick_cmd ? q_cmd.pop_front() : q_req.pop_front();
    end else if (m_v && ri) begin
      m_v = 1'b0;
    end
    if (acc_r) q_req.push_back(rd);
    if (acc_c) q_cmd.push_back(cd);
    @(posedge clk);
    #1;
    $display("cyc t=%0t rv=%0b cv=%0b ri=%0b -> v=%0b src=%0b data=%0h", $time, rv, cv, ri,
             lce_resp_v_o, grant_src_o, lce_resp_o);
    check("req_ready", req_resp_ready_o, 64'(q_req.size() < 2));
    check("cmd_ready", cmd_resp_ready_o, 64'(q_cmd.size() < 2));
    check("out_v", lce_resp_v_o, 64'(m_v));
    if (m_v) begin
      check("out_data", lce_resp_o, m_data);
      check("out_src", grant_src_o, 64'(m_src));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    int n_req_before;
    bit cmd_seen;

    // Reset state while asserted, then immediately after release.
    #2;
    check("rst_v", lce_resp_v_o, 0);
    check("rst_src", grant_src_o, 0);
    check("rst_req_ready", req_resp_ready_o, 0);
    check("rst_cmd_ready", cmd_resp_ready_o, 0);
    #1 reset_n_i = 1'b1;
    #1;
    check("post_rst_req_ready", req_resp_ready_o, 1);
    check("post_rst_cmd_ready", cmd_resp_ready_o, 1);

    // Single message: visible two edges after acceptance, gone one later.
    cycle(1'b1, 64'hA5, 1'b0, '0, 1'b1);
    check("single_not_yet", lce_resp_v_o, 0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    check("single_v", lce_resp_v_o, 1);
    check("single_data", lce_resp_o, 64'hA5);
    check("single_src", grant_src_o, 0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    check("single_gone", lce_resp_v_o, 0);

    // Simultaneous arrival: req first, then cmd on the next cycle.
    cycle(1'b1, 64'h1, 1'b1, 64'h2, 1'b1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    check("simul_first", lce_resp_o, 64'h1);
    check("simul_first_src", grant_src_o, 0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    check("simul_second", lce_resp_o, 64'h2);
    check("simul_second_src", grant_src_o, 1);
    idle(2);

    // Backpressure: offer 3 per side with the CCE stalled, then drain.
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h10 + i, 1'b1, 64'h20 + i, 1'b0);
    check("bp_req_full", req_resp_ready_o, 0);
    check("bp_cmd_full", cmd_resp_ready_o, 0);
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    check("bp_hold_data", lce_resp_o, 64'h10);
    idle(6);
    check("bp_drained", lce_resp_v_o, 0);

    // Reset mid-operation with messages queued and the output valid.
    cycle(1'b1, 64'h31, 1'b1, 64'h41, 1'b0);
    cycle(1'b1, 64'h32, 1'b1, 64'h42, 1'b0);
    reset_n_i = 1'b0;
    #1;
    check("midrst_v", lce_resp_v_o, 0);
    check("midrst_req_ready", req_resp_ready_o, 0);
    model_reset();
    #1 reset_n_i = 1'b1;
    #1;
    check("midrst_rel_req_ready", req_resp_ready_o, 1);
    check("midrst_rel_cmd_ready", cmd_resp_ready_o, 1);
    idle(3);

    // Starvation: req continuously valid, one cmd message waiting.
    n_req_before = 0;
    cmd_seen     = 1'b0;
    cycle(1'b1, 64'h100, 1'b1, 64'hC0C0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 64'h101 + i, 1'b0, '0, 1'b1);
      if (!cmd_seen && lce_resp_v_o) begin
        if (grant_src_o) cmd_seen = 1'b1;
        else n_req_before++;
      end
    end
    if (STARVE) begin
      check("starve_cmd_seen", 64'(cmd_seen), 1);
      check("starve_req_before_cmd", n_req_before, LIMIT);
    end else begin
      check("nostarve_cmd_never", 64'(cmd_seen), 0);
    end
    idle(6);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 1) == 1, {$urandom, $urandom},
            $urandom_range(0, 2) == 0, {$urandom, $urandom},
            $urandom_range(0, 9) < 7);
    end
    idle(8);
    check("final_empty", lce_resp_v_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
    $finish;
  end

endmodule
